// File: rtl/stackcalc_pkg.sv
// Shared sizing and FSM encoding for the stack calculator input path.
// Arbiter lock feature is gated by INPUT_ARB_LOCK_EN at the arbiter.
package stackcalc_pkg;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 4;
  localparam int N_REQ  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_XFER   = 2'd2
  } arb_state_t;
endpackage

// File: rtl/input_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, modulo N_REQ.
module rr_pick import stackcalc_pkg::*; (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  // Rotate so ptr lands on bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++)
      rot[i] = req[SEL_W'(i) + ptr];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) off = SEL_W'(i);
  end

  assign idx = off + ptr;
  assign any = |req;
endmodule

// File: rtl/input_arbiter.sv
// Round-robin arbiter/sequencer driving the 8-way nibble selector and handing the
// captured nibble downstream on valid/ready. Optional burst lock: INPUT_ARB_LOCK_EN.
module input_arbiter import stackcalc_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
`ifdef INPUT_ARB_LOCK_EN
  input  logic              lock,
`endif
  output logic [N_REQ-1:0]  grant,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] q_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] win;
  logic             any;

  rr_pick u_pick (.req(req), .ptr(ptr), .idx(win), .any(any));

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      sel       <= '0;
      grant     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (any) begin
          sel   <= win;
          grant <= N_REQ'(1) << win;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          out_data  <= q_in;
          out_valid <= 1'b1;
          state     <= ST_XFER;
        end
        ST_XFER: if (out_ready) begin
          out_valid <= 1'b0;
`ifdef INPUT_ARB_LOCK_EN
          // Burst: keep the grant and re-capture from the same source.
          if (lock && req[sel]) begin
            state <= ST_SETTLE;
          end else begin
            grant <= '0;
            ptr   <= sel + SEL_W'(1);
            state <= ST_IDLE;
          end
`else
          grant <= '0;
          ptr   <= sel + SEL_W'(1);
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_input_arbiter.sv
// Directed bench for input_arbiter: vector table of single transfers plus
// hand-written rotation, backpressure, async-reset and lock sequences.
module tb_input_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic [3:0] q_in;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef INPUT_ARB_LOCK_EN
  logic       lock;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  input_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
`ifdef INPUT_ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(grant), .sel(sel), .q_in(q_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  typedef struct {
    logic [7:0] req;
    logic [3:0] q;
    logic [2:0] exp_sel;
    logic       drop;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer from IDLE with ready high: grant at +1, valid at +2, done at +3.
  task automatic xfer(input vec_t v);
    req = v.req; q_in = v.q; out_ready = 1'b1;
    tick();
    chk("sel", sel, v.exp_sel);
    chk("grant", grant, 8'(1) << v.exp_sel);
    chk("busy_settle", busy, 1);
    chk("valid_settle", out_valid, 0);
    if (v.drop) req = 8'h00;
    tick();
    chk("valid_xfer", out_valid, 1);
    chk("data_xfer", out_data, v.q);
    req = 8'h00; q_in = ~v.q;
    tick();
    chk("valid_done", out_valid, 0);
    chk("grant_done", grant, 0);
    chk("busy_done", busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 8'hFF;
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_sel", sel, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    req = 8'h00;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; req = 8'h00; q_in = 4'h0; out_ready = 1'b0;
`ifdef INPUT_ARB_LOCK_EN
    lock = 1'b0;
`endif
    // ptr starts at 0; each entry's exp_sel follows from the previous winner + 1.
    vecs[0] = '{8'h08, 4'hA, 3'd3, 1'b0}; // ptr->4
    vecs[1] = '{8'hFF, 4'h5, 3'd4, 1'b0}; // proves ptr=4; ptr->5
    vecs[2] = '{8'h01, 4'h3, 3'd0, 1'b0}; // wrap; ptr->1
    vecs[3] = '{8'h81, 4'hC, 3'd7, 1'b0}; // ptr->0
    vecs[4] = '{8'h81, 4'h1, 3'd0, 1'b0}; // ptr->1
    vecs[5] = '{8'h20, 4'hF, 3'd5, 1'b0}; // ptr->6
    vecs[6] = '{8'h05, 4'h9, 3'd0, 1'b1}; // wrap+skip from 6, req dropped in SETTLE
    vecs[7] = '{8'h05, 4'h6, 3'd2, 1'b0}; // ptr=1 -> 2

    do_reset();
    for (int i = 0; i < 8; i++) xfer(vecs[i]);

    // Rotation with all requesting, from ptr=0.
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("rot_grant", grant, 8'(1) << (k % 8));
      @(posedge clk); @(posedge clk);
    end
    #1 req = 8'h00;

    // Backpressure: hold in XFER, q_in changes must not leak through.
    do_reset();
    req = 8'h08; q_in = 4'h7; out_ready = 1'b0;
    tick(); tick();
    req = 8'h00; q_in = 4'h0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 4'h7);
      chk("bp_grant", grant, 8'h08);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", out_valid, 0);

    // Async reset in XFER: outputs clear without a clock edge.
    req = 8'h02; q_in = 4'hB; out_ready = 1'b0;
    tick(); tick();
    chk("pre_rst_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sel", sel, 0);
    req = 8'h00;
    tick();
    reset = 1'b0;
    tick();

`ifdef INPUT_ARB_LOCK_EN
    // Burst lock on requester 1, then release hands over to requester 5.
    lock = 1'b1; req = 8'h22; q_in = 4'h4; out_ready = 1'b1;
    tick();
    chk("lk_sel", sel, 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("lk_valid", out_valid, 1);
      tick();
      chk("lk_busy", busy, 1);
      chk("lk_grant", grant, 8'h02);
      chk("lk_sel_hold", sel, 1);
    end
    lock = 1'b0;
    tick();
    tick();
    chk("lk_end_busy", busy, 0);
    chk("lk_end_grant", grant, 0);
    tick();
    chk("lk_next_sel", sel, 5);
    chk("lk_next_grant", grant, 8'h20);
    req = 8'h00;
    tick(); tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
